uart_loader: RTL

Program loader that sequences the byte stream from the UART receiver into instruction memory at boot. It consumes one-cycle received-byte pulses and parses a 4-byte big-endian word-count header. It then packs the following bytes into 32-bit big-endian words and writes them to consecutive memory addresses starting at 0. Completion or error is reported to the core's reset/boot logic, which holds the CPU until `done`.

---
 rtl/loader_pkg.sv | 15 +
 rtl/byte_packer.sv | 45 ++++
 rtl/uart_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_t;

    localparam int HDR_BYTES  = 4;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs bytes MSB-first into 32-bit words; word_valid pulses combinationally with the 4th byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clr) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_valid) begin
            shift_d = {shift_q[23:0], byte_data};
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // The completed word includes the byte arriving this cycle.
    assign word       = {shift_q[23:0], byte_data};
    assign word_valid = byte_valid && !clr && (idx_q == LAST_IDX);

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses a big-endian word-count header, then writes packed words to memory from address 0.
module uart_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W         = 14,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_ferr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    loader_state_t state_q, state_d;

    logic              in_load, start_ok, byte_ok, timeout_hit, last_word;
    logic [31:0]       pk_word;
    logic              pk_valid;
    logic [31:0]       n_q, n_d;
    logic [ADDR_W:0]   wl_q, wl_d, wl_inc;
    logic [31:0]       tmo_q, tmo_d;
    logic              started_q, started_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    assign in_load  = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign start_ok = start && !in_load;
    // A framing error discards any byte presented in the same cycle.
    assign byte_ok  = in_load && rx_valid && !rx_ferr;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (!in_load),
        .byte_valid (byte_ok),
        .byte_data  (rx_data),
        .word       (pk_word),
        .word_valid (pk_valid)
    );

    assign wl_inc    = wl_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word = ({{(32 - ADDR_W){1'b0}}, wl_inc} == {1'b0, n_q});

    always_comb begin
        tmo_d = tmo_q;
        if (!in_load || rx_valid) begin
            tmo_d = '0;
        end else if (started_q && (tmo_q != TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    assign started_d   = in_load && (started_q || rx_valid);
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && started_q && in_load
                         && (tmo_d == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_HDR;
            ST_HDR: begin
                if (rx_ferr || timeout_hit) begin
                    state_d = ST_ERR;
                end else if (pk_valid) begin
                    if (pk_word == 32'd0)                 state_d = ST_DONE;
                    else if ({1'b0, pk_word} > MAX_WORDS) state_d = ST_ERR;
                    else                                  state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_ferr || timeout_hit)     state_d = ST_ERR;
                else if (pk_valid && last_word) state_d = ST_DONE;
            end
            ST_DONE, ST_ERR: if (start) state_d = ST_HDR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = in_load;
        done      = (state_q == ST_DONE);
        err       = (state_q == ST_ERR);
        dbg_state = state_q;
    end

    always_comb begin
        n_d         = n_q;
        wl_d        = wl_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == ST_IDLE || start_ok) begin
            n_d  = '0;
            wl_d = '0;
        end else if (state_q == ST_HDR && pk_valid) begin
            n_d = pk_word;
        end else if (state_q == ST_DATA && pk_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wl_q[ADDR_W-1:0];
            mem_wdata_d = pk_word;
            wl_d        = wl_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q         <= '0;
            wl_q        <= '0;
            tmo_q       <= '0;
            started_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            n_q         <= n_d;
            wl_q        <= wl_d;
            tmo_q       <= tmo_d;
            started_q   <= started_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign words_loaded = wl_q;

endmodule
